// File: rtl/spi_ram_param_if.sv
// spi_ram_param_if: bus between the SPI slave deserialiser and the RAM slave.
// The master side drives command words; the slave side returns read data and status strobes.
interface spi_ram_param_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH+1:0] din;
    logic                  rx_valid;
    logic [DATA_WIDTH-1:0] dout;
    logic                  tx_valid;
    logic                  err;

    modport master (
        output din,
        output rx_valid,
        input  dout,
        input  tx_valid,
        input  err
    );

    modport slave (
        input  din,
        input  rx_valid,
        output dout,
        output tx_valid,
        output err
    );
endinterface

// File: rtl/spi_ram_param.sv
// spi_ram_param: parametrised single-port RAM slave driven by 2-bit commands.
// Each command word carries a command in its top two bits and a payload below.
// Independent read and write pointers each carry a valid flag.
// Rejected commands raise a one-cycle err strobe.
// Optional feature: define SPI_RAM_AUTOINC_EN to make each successful data command
// advance its pointer, wrapping MEM_DEPTH-1 -> 0.
module spi_ram_param #(
    parameter int DATA_WIDTH = 8,
    parameter int MEM_DEPTH  = 256
) (
    input logic            clk,
    input logic            rst_n,
    spi_ram_param_if.slave bus
);
    localparam int ADDR_SIZE = $clog2(MEM_DEPTH);
    // Wide enough to hold both the payload and MEM_DEPTH without truncation.
    localparam int CMP_W     = (DATA_WIDTH > 32) ? DATA_WIDTH + 1 : 33;

    typedef enum logic [1:0] {
        CMD_WR_ADDR = 2'b00,
        CMD_WR_DATA = 2'b01,
        CMD_RD_ADDR = 2'b10,
        CMD_RD_DATA = 2'b11
    } cmd_e;

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    logic [ADDR_SIZE-1:0]  wr_ptr_q, wr_ptr_d;
    logic [ADDR_SIZE-1:0]  rd_ptr_q, rd_ptr_d;
    logic                  wr_vld_q, wr_vld_d;
    logic                  rd_vld_q, rd_vld_d;
    logic [DATA_WIDTH-1:0] dout_q, dout_d;
    logic                  tx_valid_q, tx_valid_d;
    logic                  err_q, err_d;

    cmd_e                  cmd;
    logic [DATA_WIDTH-1:0] payload;
    logic                  addr_ok;
    logic                  mem_we;

`ifdef SPI_RAM_AUTOINC_EN
    localparam logic [ADDR_SIZE-1:0] LAST_ADDR = ADDR_SIZE'(MEM_DEPTH - 1);

    // The explicit wrap keeps non-power-of-two depths from walking off the array.
    function automatic logic [ADDR_SIZE-1:0] ptr_inc(input logic [ADDR_SIZE-1:0] p);
        return (p == LAST_ADDR) ? '0 : p + ADDR_SIZE'(1);
    endfunction
`endif

    assign cmd     = cmd_e'(bus.din[DATA_WIDTH+1:DATA_WIDTH]);
    assign payload = bus.din[DATA_WIDTH-1:0];
    assign addr_ok = CMP_W'(payload) < CMP_W'(MEM_DEPTH);

    // Decode the accepted command into next pointer, flag, read-data and strobe values.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        wr_vld_d   = wr_vld_q;
        rd_vld_d   = rd_vld_q;
        dout_d     = dout_q;
        tx_valid_d = 1'b0;
        err_d      = 1'b0;
        mem_we     = 1'b0;
        if (bus.rx_valid) begin
            unique case (cmd)
                CMD_WR_ADDR: begin
                    if (addr_ok) begin
                        wr_ptr_d = payload[ADDR_SIZE-1:0];
                        wr_vld_d = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                CMD_WR_DATA: begin
                    if (wr_vld_q) begin
                        mem_we = 1'b1;
`ifdef SPI_RAM_AUTOINC_EN
                        wr_ptr_d = ptr_inc(wr_ptr_q);
`endif
                    end else begin
                        err_d = 1'b1;
                    end
                end
                CMD_RD_ADDR: begin
                    if (addr_ok) begin
                        rd_ptr_d = payload[ADDR_SIZE-1:0];
                        rd_vld_d = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                CMD_RD_DATA: begin
                    if (rd_vld_q) begin
                        dout_d     = mem[rd_ptr_q];
                        tx_valid_d = 1'b1;
`ifdef SPI_RAM_AUTOINC_EN
                        rd_ptr_d = ptr_inc(rd_ptr_q);
`endif
                    end else begin
                        err_d = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Control state and registered outputs; memory contents are deliberately not reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            wr_vld_q   <= 1'b0;
            rd_vld_q   <= 1'b0;
            dout_q     <= '0;
            tx_valid_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_vld_q   <= wr_vld_d;
            rd_vld_q   <= rd_vld_d;
            dout_q     <= dout_d;
            tx_valid_q <= tx_valid_d;
            err_q      <= err_d;
        end
    end

    // Memory write port; a write here is visible to a read on the very next edge.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[wr_ptr_q] <= payload;
        end
    end

    assign bus.dout     = dout_q;
    assign bus.tx_valid = tx_valid_q;
    assign bus.err      = err_q;
endmodule

// File: tb/tb_spi_ram_param.sv
// tb_spi_ram_param: randomized and directed stimulus for spi_ram_param,
// checked cycle by cycle against a behavioural model of the command rules.
module tb_spi_ram_param;
    localparam int DW    = 8;
    localparam int DEPTH = 200;

`ifdef SPI_RAM_AUTOINC_EN
    localparam bit AUTOINC = 1'b1;
`else
    localparam bit AUTOINC = 1'b0;
`endif

    logic clk;
    logic rst_n;

    spi_ram_param_if #(.DATA_WIDTH(DW)) bus ();

    spi_ram_param #(
        .DATA_WIDTH(DW),
        .MEM_DEPTH (DEPTH)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int assertCount = 0;
    int failCount   = 0;

    // Reference model state.
    logic [DW-1:0] mMem [DEPTH];
    int            mWr, mRd;
    bit            mWv, mRv;
    logic [DW-1:0] expDout;
    bit            expTx, expErr;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        assertCount++;
        if (obs !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic modelReset();
        mWr = 0; mRd = 0; mWv = 0; mRv = 0;
        expDout = '0; expTx = 0; expErr = 0;
    endtask

    task automatic modelStep(input int cmd, input int payload, input bit valid);
        expTx  = 0;
        expErr = 0;
        if (valid) begin
            case (cmd)
                0: if (payload < DEPTH) begin mWr = payload; mWv = 1; end else expErr = 1;
                1: if (mWv) begin
                       mMem[mWr] = DW'(payload);
                       if (AUTOINC) mWr = (mWr + 1) % DEPTH;
                   end else expErr = 1;
                2: if (payload < DEPTH) begin mRd = payload; mRv = 1; end else expErr = 1;
                default: if (mRv) begin
                       expDout = mMem[mRd];
                       expTx   = 1;
                       if (AUTOINC) mRd = (mRd + 1) % DEPTH;
                   end else expErr = 1;
            endcase
        end
    endtask

    // Drive one word between edges, let the DUT take it, then compare all outputs.
    task automatic applyStimulus(input int cmd, input int payload, input bit valid);
        @(negedge clk);
        bus.din      = {2'(cmd), DW'(payload)};
        bus.rx_valid = valid;
        @(posedge clk);
        #1;
        modelStep(cmd, payload, valid);
        checkOutput("err", 32'(bus.err), 32'(expErr));
        checkOutput("tx_valid", 32'(bus.tx_valid), 32'(expTx));
        checkOutput("dout", 32'(bus.dout), 32'(expDout));
    endtask

    // Assert reset partway through a cycle and verify outputs clear without a clock edge.
    task automatic midCycleReset();
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        modelReset();
        checkOutput("rst_dout", 32'(bus.dout), 32'(expDout));
        checkOutput("rst_tx_valid", 32'(bus.tx_valid), 32'(expTx));
        checkOutput("rst_err", 32'(bus.err), 32'(expErr));
        bus.rx_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic readWord(input int addr);
        applyStimulus(2, addr, 1'b1);
        applyStimulus(3, 0, 1'b1);
    endtask

    initial begin
        int cmd, payload;
        bit valid;

        rst_n        = 1'b0;
        bus.din      = '0;
        bus.rx_valid = 1'b0;
        modelReset();
        #12;
        checkOutput("init_dout", 32'(bus.dout), 32'h0);
        checkOutput("init_tx_valid", 32'(bus.tx_valid), 32'h0);
        checkOutput("init_err", 32'(bus.err), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Data command before any address command is rejected.
        applyStimulus(3, 0, 1'b1);
        applyStimulus(1, 8'h55, 1'b1);

        // Give every word a known value so later reads are fully predictable.
        for (int a = 0; a < DEPTH; a++) begin
            applyStimulus(0, a, 1'b1);
            applyStimulus(1, $urandom_range(0, 255), 1'b1);
        end

        $display("[TB] basic write/read");
        applyStimulus(0, 8'h3C, 1'b1);
        applyStimulus(1, 8'hA5, 1'b1);
        applyStimulus(2, 8'h3C, 1'b1);
        applyStimulus(3, 0, 1'b1);
        applyStimulus(0, 0, 1'b0);

        $display("[TB] write then immediate read of same word");
        applyStimulus(0, 8'h40, 1'b1);
        applyStimulus(2, 8'h40, 1'b1);
        applyStimulus(1, 8'h6E, 1'b1);
        applyStimulus(3, 0, 1'b1);

        $display("[TB] reset mid-burst and range check");
        midCycleReset();
        applyStimulus(3, 0, 1'b1);
        applyStimulus(0, 8'hD0, 1'b1);
        applyStimulus(1, 8'h11, 1'b1);
        applyStimulus(0, DEPTH, 1'b1);
        applyStimulus(2, DEPTH - 1, 1'b1);
        applyStimulus(3, 0, 1'b1);
        readWord(0);
        readWord(8'h3C);

        $display("[TB] burst across the top of memory");
        applyStimulus(0, DEPTH - 2, 1'b1);
        applyStimulus(1, 8'h01, 1'b1);
        applyStimulus(1, 8'h02, 1'b1);
        applyStimulus(1, 8'h03, 1'b1);
        applyStimulus(2, DEPTH - 2, 1'b1);
        applyStimulus(3, 0, 1'b1);
        applyStimulus(3, 0, 1'b1);
        applyStimulus(3, 0, 1'b1);
        readWord(0);
        readWord(DEPTH - 1);

        $display("[TB] repeated data commands");
        applyStimulus(0, 8'h10, 1'b1);
        applyStimulus(1, 8'h22, 1'b1);
        applyStimulus(1, 8'h33, 1'b1);
        readWord(8'h10);
        readWord(8'h11);

        $display("[TB] rx_valid gating");
        readWord(8'h05);
        applyStimulus(3, 0, 1'b0);
        applyStimulus(0, 8'hE0, 1'b0);
        applyStimulus(1, 8'h99, 1'b0);
        applyStimulus(3, 0, 1'b1);

        $display("[TB] randomized traffic");
        for (int i = 0; i < 1500; i++) begin
            cmd   = $urandom_range(0, 3);
            valid = ($urandom_range(0, 9) < 8);
            if ((cmd == 0 || cmd == 2) && $urandom_range(0, 3) != 0)
                payload = $urandom_range(0, DEPTH - 1);
            else
                payload = $urandom_range(0, 255);
            applyStimulus(cmd, payload, valid);
            if (i == 700) midCycleReset();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end
endmodule
